// File: rtl/sfp_accum_seq_pkg.sv
// Shared definitions for the accumulate/ReLU sequencer: FSM state encoding
// and the width rule for the saturating per-column adder.
package sfp_accum_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_RELU = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  // One guard bit is enough to detect overflow of a two-operand signed add.
  localparam int SAT_GUARD_BITS = 1;

  function automatic int sum_width(input int w);
    return w + SAT_GUARD_BITS;
  endfunction

endpackage

// File: rtl/sfp_lane.sv
// One column: saturating accumulator plus a registered threshold-ReLU result.
module sfp_lane
  import sfp_accum_seq_pkg::*;
#(
  parameter int psum_bw = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_clear,
  input  logic                      i_acc_en,
  input  logic                      i_relu_ld,
  input  logic                      i_relu_en,
  input  logic signed [psum_bw-1:0] i_thres,
  input  logic signed [psum_bw-1:0] i_data,
  output logic signed [psum_bw-1:0] o_res
);

  localparam int SW = sum_width(psum_bw);
  localparam logic signed [SW-1:0] SUM_MAX = {{(SW-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MIN = {{(SW-psum_bw+1){1'b1}}, {(psum_bw-1){1'b0}}};

  logic signed [psum_bw-1:0] r_acc;
  logic signed [psum_bw-1:0] r_res;
  logic signed [SW-1:0]      w_sum;
  logic signed [psum_bw-1:0] w_sat;

  always_comb begin
    w_sum = $signed({{SAT_GUARD_BITS{r_acc[psum_bw-1]}}, r_acc})
          + $signed({{SAT_GUARD_BITS{i_data[psum_bw-1]}}, i_data});
    if (w_sum > SUM_MAX)
      w_sat = SUM_MAX[psum_bw-1:0];
    else if (w_sum < SUM_MIN)
      w_sat = SUM_MIN[psum_bw-1:0];
    else
      w_sat = w_sum[psum_bw-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_res <= '0;
    end else begin
      if (i_clear)
        r_acc <= '0;
      else if (i_acc_en)
        r_acc <= w_sat;
      // Result register is only written in RELU so the output holds afterwards.
      if (i_relu_ld)
        r_res <= (i_relu_en && (r_acc < i_thres)) ? i_thres : r_acc;
    end
  end

  assign o_res = r_res;

endmodule

// File: rtl/sfp_accum_seq.sv
// Column-parallel accumulate/ReLU stage with its own sequencer, pulling
// partial sums from the OFIFO or the psum memory and returning a valid/ready result.
module sfp_accum_seq
  import sfp_accum_seq_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int len_bw  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      src_sel,
  input  logic [len_bw-1:0]         acc_len,
  input  logic                      relu_en,
  input  logic [psum_bw-1:0]        thres,
  input  logic [col*psum_bw-1:0]    fifo_data,
  input  logic                      fifo_valid,
  output logic                      fifo_rd,
  input  logic [col*psum_bw-1:0]    psum_data,
  input  logic                      psum_valid,
  output logic [col*psum_bw-1:0]    out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done
);

  logic [1:0]               r_state;
  logic [len_bw-1:0]        r_cnt;
  logic [len_bw-1:0]        r_len;
  logic                     r_src_sel;
  logic                     r_relu_en;
  logic [psum_bw-1:0]       r_thres;

  logic                     w_start_ok;
  logic                     w_beat;
  logic                     w_last;
  logic [len_bw:0]          w_cnt_inc;
  logic [col*psum_bw-1:0]   w_data;

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_beat     = (r_state == ST_ACC) && (r_src_sel ? psum_valid : fifo_valid);
  assign w_cnt_inc  = {1'b0, r_cnt} + {{len_bw{1'b0}}, 1'b1};
  assign w_last     = w_beat && (w_cnt_inc == {1'b0, r_len});
  assign w_data     = r_src_sel ? psum_data : fifo_data;

  assign fifo_rd   = (r_state == ST_ACC) && !r_src_sel && fifo_valid;
  assign out_valid = (r_state == ST_OUT);
  assign done      = out_valid && out_ready;
  assign busy      = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_len     <= '0;
      r_src_sel <= 1'b0;
      r_relu_en <= 1'b0;
      r_thres   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_src_sel <= src_sel;
            r_relu_en <= relu_en;
            r_thres   <= thres;
            // A zero length still performs one beat.
            r_len     <= (acc_len == '0) ? len_bw'(1) : acc_len;
            r_cnt     <= '0;
            r_state   <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (w_beat) begin
            r_cnt <= w_cnt_inc[len_bw-1:0];
            if (w_last)
              r_state <= ST_RELU;
          end
        end
        ST_RELU: r_state <= ST_OUT;
        default: begin
          if (out_ready)
            r_state <= ST_IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_lane
      sfp_lane #(.psum_bw(psum_bw)) u_lane (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_start_ok),
        .i_acc_en  (w_beat),
        .i_relu_ld (r_state == ST_RELU),
        .i_relu_en (r_relu_en),
        .i_thres   ($signed(r_thres)),
        .i_data    ($signed(w_data[psum_bw*(gi+1)-1 -: psum_bw])),
        .o_res     (out_data[psum_bw*(gi+1)-1 -: psum_bw])
      );
    end
  endgenerate

endmodule
